// File: rtl/fft_controller.sv
// 64-point radix-2 DIT FFT engine over two ping-pong 64x32 banks, one butterfly per cycle.
// Input frames are written bit-reversed so output bins come out in natural order.
module fft_controller #(
  parameter int BW    = 16,
  parameter int LOG2N = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             load,
  input  logic [LOG2N-1:0] rd_adr,
  input  logic [2*BW-1:0]  rd,
  output logic             done,
  output logic [2*BW-1:0]  wd
);
  localparam int N    = 1 << LOG2N;
  localparam int HALF = N / 2;
  localparam int PW   = 2 * BW;
  localparam int AW   = 2 * BW + 1;
  localparam int SW   = $clog2(LOG2N);

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DONE} state_t;

  state_t           state_q;
  logic [SW-1:0]    stage_q;
  logic [LOG2N-1:0] cnt_q;
  logic             done_q;
  logic [2*BW-1:0]  wd_q;

  logic [2*BW-1:0]  bank_a [N];
  logic [2*BW-1:0]  bank_b [N];

  logic [LOG2N-2:0] bfly, mask, tw_idx;
  logic [LOG2N-1:0] ia, ib;
  logic             issue;

  logic [2*BW-1:0]  a_p0, b_p0, tw_p0;
  logic [LOG2N-1:0] ia_p0, ib_p0;
  logic             tw0_p0, wr_a_p0, vld_p0;

  logic signed [BW-1:0] ar, ai, br, bi, wr, wi, tr, ti;
  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
  logic [2*BW-1:0]      a_d, b_d;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    for (int i = 0; i < LOG2N; i++) bitrev[i] = a[LOG2N-1-i];
  endfunction

  // {cos, -sin} of 2*pi*k/64 in Q1.15
  function automatic logic [2*BW-1:0] twiddle(input logic [LOG2N-2:0] idx);
    twiddle = '0;
    case (idx)
      5'd0:  twiddle = 32'h7FFF_0000;  5'd1:  twiddle = 32'h7F61_F374;
      5'd2:  twiddle = 32'h7D89_E707;  5'd3:  twiddle = 32'h7A7C_DAD8;
      5'd4:  twiddle = 32'h7641_CF05;  5'd5:  twiddle = 32'h70E2_C3AA;
      5'd6:  twiddle = 32'h6A6D_B8E4;  5'd7:  twiddle = 32'h62F1_AECD;
      5'd8:  twiddle = 32'h5A82_A57E;  5'd9:  twiddle = 32'h5133_9D0F;
      5'd10: twiddle = 32'h471C_9593;  5'd11: twiddle = 32'h3C56_8F1E;
      5'd12: twiddle = 32'h30FB_89BF;  5'd13: twiddle = 32'h2528_8584;
      5'd14: twiddle = 32'h18F9_8277;  5'd15: twiddle = 32'h0C8C_809F;
      5'd16: twiddle = 32'h0000_8001;  5'd17: twiddle = 32'hF374_809F;
      5'd18: twiddle = 32'hE707_8277;  5'd19: twiddle = 32'hDAD8_8584;
      5'd20: twiddle = 32'hCF05_89BF;  5'd21: twiddle = 32'hC3AA_8F1E;
      5'd22: twiddle = 32'hB8E4_9593;  5'd23: twiddle = 32'hAECD_9D0F;
      5'd24: twiddle = 32'hA57E_A57E;  5'd25: twiddle = 32'h9D0F_AECD;
      5'd26: twiddle = 32'h9593_B8E4;  5'd27: twiddle = 32'h8F1E_C3AA;
      5'd28: twiddle = 32'h89BF_CF05;  5'd29: twiddle = 32'h8584_DAD8;
      5'd30: twiddle = 32'h8277_E707;  5'd31: twiddle = 32'h809F_F374;
    endcase
  endfunction

  function automatic logic signed [BW-1:0] trunc_q15(input logic signed [AW-1:0] acc);
    return acc[2*BW-2:BW-1];
  endfunction

  function automatic logic signed [BW-1:0] half_sum(input logic signed [BW-1:0] x,
                                                    input logic signed [BW-1:0] y,
                                                    input logic sub);
    logic signed [BW:0] s;
    s = sub ? ((BW+1)'(x) - (BW+1)'(y)) : ((BW+1)'(x) + (BW+1)'(y));
    return s[BW:1];
  endfunction

  // Butterfly b of stage s: insert a zero at bit s to get the upper leg, set it for the lower leg
  always_comb begin
    bfly   = cnt_q[LOG2N-2:0];
    mask   = {(LOG2N-1){1'b1}} >> (SW'(LOG2N-1) - stage_q);
    ia     = {bfly & ~mask, 1'b0} | {1'b0, bfly & mask};
    ib     = ia | (LOG2N'(1) << stage_q);
    tw_idx = (bfly & mask) << (SW'(LOG2N-1) - stage_q);
    issue  = (state_q == COMPUTE) && !cnt_q[LOG2N-1];
  end

  // p0: registered bank read of both legs plus twiddle
  always_ff @(posedge clk) begin
    if (issue) begin
      a_p0    <= stage_q[0] ? bank_b[ia] : bank_a[ia];
      b_p0    <= stage_q[0] ? bank_b[ib] : bank_a[ib];
      ia_p0   <= ia;
      ib_p0   <= ib;
      tw_p0   <= twiddle(tw_idx);
      tw0_p0  <= (tw_idx == '0);
      wr_a_p0 <= stage_q[0];
    end
    if (load && !reset) begin
      bank_a[bitrev(rd_adr)] <= rd;
    end else if (vld_p0 && wr_a_p0) begin
      bank_a[ia_p0] <= a_d;
      bank_a[ib_p0] <= b_d;
    end
    if (vld_p0 && !wr_a_p0) begin
      bank_b[ia_p0] <= a_d;
      bank_b[ib_p0] <= b_d;
    end
  end

  // W^0 is applied as an exact unity so the 0x7FFF ROM entry cannot bias DC bins downward
  always_comb begin
    ar   = a_p0[2*BW-1:BW];
    ai   = a_p0[BW-1:0];
    br   = b_p0[2*BW-1:BW];
    bi   = b_p0[BW-1:0];
    wr   = tw_p0[2*BW-1:BW];
    wi   = tw_p0[BW-1:0];
    p_rr = PW'(br) * PW'(wr);
    p_ii = PW'(bi) * PW'(wi);
    p_ri = PW'(br) * PW'(wi);
    p_ir = PW'(bi) * PW'(wr);
    tr   = tw0_p0 ? br : trunc_q15(AW'(p_rr) - AW'(p_ii));
    ti   = tw0_p0 ? bi : trunc_q15(AW'(p_ri) + AW'(p_ir));
    a_d  = {half_sum(ar, tr, 1'b0), half_sum(ai, ti, 1'b0)};
    b_d  = {half_sum(ar, tr, 1'b1), half_sum(ai, ti, 1'b1)};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      stage_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      wd_q    <= '0;
      vld_p0  <= 1'b0;
    end else if (load) begin
      state_q <= LOAD;
      done_q  <= 1'b0;
      wd_q    <= '0;
      vld_p0  <= 1'b0;
    end else begin
      vld_p0 <= issue;
      case (state_q)
        COMPUTE: begin
          if (stage_q == SW'(LOG2N-1) && cnt_q == LOG2N'(HALF+1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            wd_q    <= bank_a[rd_adr];
          end else if (stage_q != SW'(LOG2N-1) && cnt_q == LOG2N'(HALF)) begin
            stage_q <= stage_q + SW'(1);
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + LOG2N'(1);
          end
        end
        default: begin
          if (start) begin
            state_q <= COMPUTE;
            stage_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            wd_q    <= '0;
          end else if (state_q == DONE) begin
            wd_q <= bank_a[rd_adr];
          end
        end
      endcase
    end
  end

  assign done = done_q;
  assign wd   = wd_q;
endmodule

// File: tb/tb_fft_controller.sv
// Directed bench for fft_controller: scoreboard of expected bins, immediate-assert checks.
module tb_fft_controller;
  logic        clk = 1'b0;
  logic        reset, start, load;
  logic [5:0]  rd_adr;
  logic [31:0] rd;
  logic        done;
  logic [31:0] wd;

  typedef struct { logic [31:0] exp; int tol; } sb_t;
  sb_t         sbq[$];
  logic [31:0] frame   [64];
  logic [31:0] exp_bin [64];
  int          tol_bin [64];
  int          tw_re   [32];
  int          tw_im   [32];
  int          n_chk = 0;
  int          n_pass = 0;

  fft_controller #(.BW(16), .LOG2N(6)) dut (
    .clk(clk), .reset(reset), .start(start), .load(load),
    .rd_adr(rd_adr), .rd(rd), .done(done), .wd(wd)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic check_word(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp, input int tol);
    logic ok;
    int   dr, di;
    dr = int'($signed(obs[31:16])) - int'($signed(exp[31:16]));
    di = int'($signed(obs[15:0]))  - int'($signed(exp[15:0]));
    ok = (tol == 0) ? (obs === exp)
                    : (!$isunknown(obs) && iabs(dr) <= tol && iabs(di) <= tol);
    n_chk++;
    assert (ok) n_pass++;
    else $error("FAIL %s: observed %h expected %h (tol %0d)", tag, obs, exp, tol);
  endtask

  task automatic load_frame();
    for (int n = 0; n < 64; n++) begin
      load = 1'b1; rd_adr = 6'(n); rd = frame[n];
      tick();
    end
    load = 1'b0; rd = '0; rd_adr = '0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Counts edges after the start edge until done rises, bounded
  task automatic wait_done(input int already, input string tag);
    int n;
    n = already;
    while (done !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    check_word(tag, 32'(n), 32'd199, 0);
  endtask

  task automatic read_bins(input int count, input string tag, input bit chk_done);
    sb_t e;
    for (int i = 0; i < count; i++) begin
      rd_adr = 6'(i);
      sbq.push_back('{exp: exp_bin[i % 64], tol: tol_bin[i % 64]});
      tick();
      e = sbq.pop_front();
      check_word(tag, wd, e.exp, e.tol);
      if (chk_done) check_word("done_hold", 32'(done), 32'd1, 0);
    end
  endtask

  // Fixed-point DIT reference, evaluated stage by stage on integer arrays
  task automatic compute_model();
    int     re [64];
    int     im [64];
    int     r, span, ia, ib, ti, tr, tim, ar, ai;
    longint pr, pim;
    for (int n = 0; n < 64; n++) begin
      r = 0;
      for (int j = 0; j < 6; j++) if (n & (1 << j)) r |= 1 << (5 - j);
      re[r] = int'($signed(frame[n][31:16]));
      im[r] = int'($signed(frame[n][15:0]));
    end
    for (int s = 0; s < 6; s++) begin
      span = 1 << s;
      for (int base = 0; base < 64; base += 2 * span) begin
        for (int k = 0; k < span; k++) begin
          ia = base + k;
          ib = ia + span;
          ti = k * (32 / span);
          if (ti == 0) begin
            tr = re[ib]; tim = im[ib];
          end else begin
            pr  = longint'(re[ib]) * tw_re[ti] - longint'(im[ib]) * tw_im[ti];
            pim = longint'(re[ib]) * tw_im[ti] + longint'(im[ib]) * tw_re[ti];
            tr  = int'(shortint'(pr >>> 15));
            tim = int'(shortint'(pim >>> 15));
          end
          ar = re[ia]; ai = im[ia];
          re[ia] = (ar + tr) >>> 1;  im[ia] = (ai + tim) >>> 1;
          re[ib] = (ar - tr) >>> 1;  im[ib] = (ai - tim) >>> 1;
        end
      end
    end
    for (int k = 0; k < 64; k++) exp_bin[k] = {16'(re[k]), 16'(im[k])};
  endtask

  initial begin
    for (int k = 0; k < 32; k++) begin
      tw_re[k] = int'($floor(32767.0 * $cos(2.0 * 3.14159265358979 * k / 64.0) + 0.5));
      tw_im[k] = int'($floor(-32767.0 * $sin(2.0 * 3.14159265358979 * k / 64.0) + 0.5));
    end
    reset = 1'b1; start = 1'b0; load = 1'b0; rd_adr = '0; rd = '0;
    repeat (2) tick();
    check_word("reset_done", 32'(done), 32'd0, 0);
    check_word("reset_wd", wd, 32'd0, 0);
    reset = 1'b0;

    // Impulse: every bin is 32767/64 truncated
    for (int n = 0; n < 64; n++) frame[n] = (n == 0) ? 32'h7FFF0000 : 32'h0;
    load_frame();
    check_word("load_done_low", 32'(done), 32'd0, 0);
    pulse_start();
    wait_done(0, "impulse_latency");
    for (int k = 0; k < 64; k++) begin exp_bin[k] = 32'h01FF0000; tol_bin[k] = 0; end
    read_bins(64, "impulse_bin", 1'b0);

    // Load while done is high drops done; a start mid-compute changes nothing
    load = 1'b1; rd_adr = '0; rd = 32'h04000000;
    tick();
    load = 1'b0;
    check_word("load_clears_done", 32'(done), 32'd0, 0);
    check_word("load_clears_wd", wd, 32'd0, 0);
    for (int n = 0; n < 64; n++) frame[n] = 32'h04000000;
    load_frame();
    pulse_start();
    repeat (20) tick();
    pulse_start();
    wait_done(21, "dc_latency_with_restart");
    for (int k = 0; k < 64; k++) begin
      exp_bin[k] = (k == 0) ? 32'h04000000 : 32'h0; tol_bin[k] = 0;
    end
    read_bins(64, "dc_bin", 1'b0);

    // Zero frame, reading past 63 so the address wraps
    for (int n = 0; n < 64; n++) frame[n] = 32'h0;
    load_frame();
    rd_adr = 6'd5;
    pulse_start();
    check_word("wd_zero_in_compute", wd, 32'd0, 0);
    wait_done(0, "zero_latency");
    for (int k = 0; k < 64; k++) begin exp_bin[k] = 32'h0; tol_bin[k] = 0; end
    read_bins(70, "zero_bin", 1'b1);

    // Reset 50 cycles into a transform aborts it
    for (int n = 0; n < 64; n++) frame[n] = (n < 32) ? 32'h10000000 : 32'hF0000000;
    load_frame();
    pulse_start();
    repeat (50) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_word("abort_done", 32'(done), 32'd0, 0);
    check_word("abort_wd", wd, 32'd0, 0);
    repeat (250) tick();
    check_word("abort_stays_idle", 32'(done), 32'd0, 0);

    // Partial stages overwrote bank A, so the frame is reloaded before the fresh run
    load_frame();
    pulse_start();
    wait_done(0, "square_latency");
    compute_model();
    for (int k = 0; k < 64; k++) begin
      if (k >= 2 && (k % 2) == 0) begin exp_bin[k] = 32'h0; tol_bin[k] = 0; end
      else tol_bin[k] = 1;
    end
    read_bins(64, "square_bin", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
